pipeline_hazard_ctrl: RTL

- Hazard and forwarding controller for the 5-stage xgriscv pipeline.
- Keeps its own shadow pipeline of register tags for the E, M and W stages, fed from decode-stage fields.
- Generates stall, flush and bubble controls for the IF/ID and ID/EX registers, E-stage forwarding selects, and D-stage write-back bypass.
- Sits beside the datapath; the datapath pipeline registers consume its controls.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipeline_hazard_ctrl_tag_reg.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module : xgriscv_hazard_pkg
// Brief  : Shared constants for the xgriscv hazard/forwarding controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package xgriscv_hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int RFIDX_W_DEF = 5;

    // Tag record {rd, rs1, rs2, use1, use2, regwrite, memtoreg}, flags in the low bits
    localparam int TAG_MEMTOREG_BIT = 0;
    localparam int TAG_REGWRITE_BIT = 1;
    localparam int TAG_USE2_BIT     = 2;
    localparam int TAG_USE1_BIT     = 3;
    localparam int TAG_FLAG_W       = 4;

    function automatic int tag_width(input int idx_w);
        return 3 * idx_w + TAG_FLAG_W;
    endfunction

    localparam int TAG_W = 3 * RFIDX_W_DEF + TAG_FLAG_W;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_tag_reg.sv
// ============================================================================
// Module : hazard_tag_reg
// Brief  : One shadow-pipeline tag register; bubble kills regwrite/memtoreg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_tag_reg
    import xgriscv_hazard_pkg::*;
#(
    parameter int W = TAG_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] kill_mask;

    always_comb begin
        kill_mask                   = '1;
        kill_mask[TAG_REGWRITE_BIT] = 1'b0;
        kill_mask[TAG_MEMTOREG_BIT] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= d & kill_mask;
        end else begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Stall/flush/forwarding/bypass controller for the 5-stage xgriscv.
//          Define HAZARD_PERF_EN to build the stall/flush event counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import xgriscv_hazard_pkg::*;
#(
    parameter int RFIDX_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RFIDX_W-1:0] rs1D,
    input  logic [RFIDX_W-1:0] rs2D,
    input  logic [RFIDX_W-1:0] rdD,
    input  logic               use1D,
    input  logic               use2D,
    input  logic               regwriteD,
    input  logic               memtoregD,
    input  logic               redirectE,
    output logic               stallF,
    output logic               stallD,
    output logic               flushD,
    output logic               flushE,
    output logic [1:0]         fwdaE,
    output logic [1:0]         fwdbE,
    output logic               byp1D,
    output logic               byp2D,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int TW     = tag_width(RFIDX_W);
    localparam int RS2_LO = TAG_FLAG_W;
    localparam int RS1_LO = TAG_FLAG_W + RFIDX_W;
    localparam int RD_LO  = TAG_FLAG_W + 2 * RFIDX_W;

    logic [TW-1:0] tag_d, tag_e, tag_m, tag_w;
    logic          bubble_e;
    logic          lu_raw, lu;

    assign tag_d = {rdD, rs1D, rs2D, use1D, use2D, regwriteD, memtoregD};

    hazard_tag_reg #(.W(TW)) u_tag_e (
        .clk(clk), .reset(reset), .bubble(bubble_e), .d(tag_d), .q(tag_e)
    );
    hazard_tag_reg #(.W(TW)) u_tag_m (
        .clk(clk), .reset(reset), .bubble(1'b0), .d(tag_e), .q(tag_m)
    );
    hazard_tag_reg #(.W(TW)) u_tag_w (
        .clk(clk), .reset(reset), .bubble(1'b0), .d(tag_m), .q(tag_w)
    );

    logic [RFIDX_W-1:0] rd_e, rs1_e, rs2_e, rd_m, rd_w;
    logic               use1_e, use2_e, regwrite_e, memtoreg_e, regwrite_m, regwrite_w;

    assign rd_e       = tag_e[RD_LO  +: RFIDX_W];
    assign rs1_e      = tag_e[RS1_LO +: RFIDX_W];
    assign rs2_e      = tag_e[RS2_LO +: RFIDX_W];
    assign use1_e     = tag_e[TAG_USE1_BIT];
    assign use2_e     = tag_e[TAG_USE2_BIT];
    assign regwrite_e = tag_e[TAG_REGWRITE_BIT];
    assign memtoreg_e = tag_e[TAG_MEMTOREG_BIT];
    assign rd_m       = tag_m[RD_LO +: RFIDX_W];
    assign regwrite_m = tag_m[TAG_REGWRITE_BIT];
    assign rd_w       = tag_w[RD_LO +: RFIDX_W];
    assign regwrite_w = tag_w[TAG_REGWRITE_BIT];

    // W-stage source fields and load flag never steer anything
    logic unused_tag_w;
    assign unused_tag_w = ^{tag_w[RD_LO-1:TAG_REGWRITE_BIT+1], tag_w[TAG_MEMTOREG_BIT]};

    function automatic logic [1:0] fwd_sel(
        input logic [RFIDX_W-1:0] src,
        input logic               use_src,
        input logic               wr_m,
        input logic [RFIDX_W-1:0] dst_m,
        input logic               wr_w,
        input logic [RFIDX_W-1:0] dst_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && src != '0) begin
            if (wr_m && dst_m == src) begin
                sel = FWD_M;
            end else if (wr_w && dst_w == src) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    assign fwdaE = fwd_sel(rs1_e, use1_e, regwrite_m, rd_m, regwrite_w, rd_w);
    assign fwdbE = fwd_sel(rs2_e, use2_e, regwrite_m, rd_m, regwrite_w, rd_w);

    assign lu_raw = memtoreg_e & regwrite_e & (rd_e != '0)
                  & ((use1D & (rd_e == rs1D)) | (use2D & (rd_e == rs2D)));
    // A redirect kills the D instruction, so its dependency is moot
    assign lu     = lu_raw & ~redirectE;

    assign stallF   = lu;
    assign stallD   = lu;
    assign flushD   = redirectE;
    assign flushE   = lu | redirectE;
    assign bubble_e = flushE;

    assign byp1D = regwrite_w & (rd_w == rs1D) & (rd_w != '0) & use1D;
    assign byp2D = regwrite_w & (rd_w == rs2D) & (rd_w != '0) & use2D;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (lu && stall_q != '1) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (redirectE && flush_q != '1) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire
